// File: rtl/stream_sel_pkg.sv
// Shared types and helpers for the stream select multiplexer and its arbiter.
package stream_sel_pkg;

    typedef enum logic {
        MODE_SEL = 1'b0,
        MODE_RR  = 1'b1
    } mode_e;

    // Channel index increment wrapping at n_ch.
    function automatic int unsigned next_ch(input int unsigned ch, input int unsigned n_ch);
        if (ch + 32'd1 >= n_ch) begin
            return 32'd0;
        end else begin
            return ch + 32'd1;
        end
    endfunction

endpackage

// File: rtl/rr_lock_arbiter.sv
// Round-robin arbiter that locks onto a channel for the duration of a packet.
module rr_lock_arbiter
    import stream_sel_pkg::*;
#(
    parameter int N_CH  = 6,
    parameter int SEL_W = $clog2(N_CH)
) (
    input  logic             clk,
    input  logic             areset_n,
    input  logic [N_CH-1:0]  req_i,
    input  logic [N_CH-1:0]  last_i,
    input  logic             accept_i,
    input  logic             en_i,
    output logic [SEL_W-1:0] grant_idx_o,
    output logic             grant_vld_o
);

    logic [SEL_W-1:0] rr_ptr_q, rr_ptr_d;
    logic             lock_q, lock_d;
    logic [SEL_W-1:0] lock_ch_q, lock_ch_d;
    logic [SEL_W-1:0] grant_idx_s;
    logic             grant_vld_s;
    int               c;

    // Grant search: locked channel only, else first requester from rr_ptr (scanned backwards so nearest wins).
    always_comb begin
        c           = 0;
        grant_idx_s = lock_ch_q;
        grant_vld_s = 1'b0;
        if (lock_q) begin
            grant_vld_s = req_i[lock_ch_q];
        end else begin
            for (int k = N_CH - 1; k >= 0; k--) begin
                c = (int'(rr_ptr_q) + k >= N_CH) ? int'(rr_ptr_q) + k - N_CH : int'(rr_ptr_q) + k;
                grant_idx_s = req_i[c] ? SEL_W'(c) : grant_idx_s;
                grant_vld_s = grant_vld_s | req_i[c];
            end
        end
    end

    // Lock/pointer next state, advanced only by accepted round-robin beats.
    always_comb begin
        rr_ptr_d  = rr_ptr_q;
        lock_d    = lock_q;
        lock_ch_d = lock_ch_q;
        if (en_i && accept_i && grant_vld_s) begin
            if (last_i[grant_idx_s]) begin
                lock_d   = 1'b0;
                rr_ptr_d = SEL_W'(next_ch(32'(grant_idx_s), N_CH));
            end else begin
                lock_d    = 1'b1;
                lock_ch_d = grant_idx_s;
            end
        end else begin
            lock_d = lock_q;
        end
    end

    // Arbiter state registers.
    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            rr_ptr_q  <= {SEL_W{1'b0}};
            lock_q    <= 1'b0;
            lock_ch_q <= {SEL_W{1'b0}};
        end else begin
            rr_ptr_q  <= rr_ptr_d;
            lock_q    <= lock_d;
            lock_ch_q <= lock_ch_d;
        end
    end

    assign grant_idx_o = grant_idx_s;
    assign grant_vld_o = grant_vld_s;

endmodule

// File: rtl/stream_sel_mux.sv
// N-channel valid/ready stream multiplexer with explicit-select and packet-locked
// round-robin modes, followed by a single registered output stage.
module stream_sel_mux
    import stream_sel_pkg::*;
#(
    parameter  int N_CH  = 6,
    parameter  int WIDTH = 4,
    localparam int SEL_W = $clog2(N_CH)
) (
    input  logic                  clk,
    input  logic                  areset_n,
    input  logic                  mode,
    input  logic [SEL_W-1:0]      sel,
    input  logic [N_CH-1:0]       in_valid,
    output logic [N_CH-1:0]       in_ready,
    input  logic [N_CH*WIDTH-1:0] in_data,
    input  logic [N_CH-1:0]       in_last,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [WIDTH-1:0]      out_data,
    output logic                  out_last,
    output logic [SEL_W-1:0]      out_ch,
    output logic                  err_sel
);

    localparam int               SEL_W1 = SEL_W + 1;
    localparam logic [SEL_W:0]   N_CH_L = SEL_W1'(N_CH);

    logic             mode_rr_s, sel_ok_s, load_en_s, xfer_s;
    logic [SEL_W-1:0] arb_idx_s, grant_idx_s;
    logic             arb_vld_s, grant_vld_s;
    logic [WIDTH-1:0] mux_data_s;
    logic             mux_last_s;

    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic             out_last_q, out_last_d;
    logic [SEL_W-1:0] out_ch_q, out_ch_d;
    logic             err_sel_q, err_sel_d;

    assign mode_rr_s = (mode == MODE_RR);
    assign sel_ok_s  = ({1'b0, sel} < N_CH_L);
    assign load_en_s = !out_valid_q || out_ready;
    assign xfer_s    = grant_vld_s && load_en_s;

    rr_lock_arbiter #(
        .N_CH  (N_CH),
        .SEL_W (SEL_W)
    ) u_arb (
        .clk         (clk),
        .areset_n    (areset_n),
        .req_i       (in_valid),
        .last_i      (in_last),
        .accept_i    (xfer_s),
        .en_i        (mode_rr_s),
        .grant_idx_o (arb_idx_s),
        .grant_vld_o (arb_vld_s)
    );

    // Mode-dependent grant; the arbiter's lock is simply ignored in select mode.
    always_comb begin
        grant_idx_s = sel;
        grant_vld_s = 1'b0;
        if (mode_rr_s) begin
            grant_idx_s = arb_idx_s;
            grant_vld_s = arb_vld_s;
        end else begin
            grant_idx_s = sel;
            grant_vld_s = sel_ok_s && in_valid[sel];
        end
    end

    // Ready decode and data/last steering from the granted channel.
    always_comb begin
        in_ready   = {N_CH{1'b0}};
        mux_data_s = {WIDTH{1'b0}};
        mux_last_s = 1'b0;
        for (int i = 0; i < N_CH; i++) begin
            in_ready[i] = xfer_s && (grant_idx_s == SEL_W'(i));
            mux_data_s  = (grant_idx_s == SEL_W'(i)) ? in_data[i*WIDTH +: WIDTH] : mux_data_s;
            mux_last_s  = (grant_idx_s == SEL_W'(i)) ? in_last[i] : mux_last_s;
        end
    end

    // Output stage next state: load, drain to zero, or hold under backpressure.
    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_last_d  = out_last_q;
        out_ch_d    = out_ch_q;
        err_sel_d   = !mode_rr_s && !sel_ok_s && (|in_valid);
        if (xfer_s) begin
            out_valid_d = 1'b1;
            out_data_d  = mux_data_s;
            out_last_d  = mux_last_s;
            out_ch_d    = grant_idx_s;
        end else if (load_en_s) begin
            out_valid_d = 1'b0;
            out_data_d  = {WIDTH{1'b0}};
            out_last_d  = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end
    end

    // Output and error registers.
    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            out_valid_q <= 1'b0;
            out_data_q  <= {WIDTH{1'b0}};
            out_last_q  <= 1'b0;
            out_ch_q    <= {SEL_W{1'b0}};
            err_sel_q   <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
            out_ch_q    <= out_ch_d;
            err_sel_q   <= err_sel_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_last  = out_last_q;
    assign out_ch    = out_ch_q;
    assign err_sel   = err_sel_q;

endmodule

// File: tb/tb_stream_sel_mux.sv
// Self-checking bench for stream_sel_mux against a cycle-level behavioural model.
module tb_stream_sel_mux;

    localparam int N_CH  = 6;
    localparam int WIDTH = 4;

    logic        clk = 1'b0;
    logic        areset_n = 1'b0;
    logic        mode_s = 1'b0;
    logic [2:0]  sel_s = 3'd0;
    logic [5:0]  in_valid_s = 6'd0;
    logic [5:0]  in_last_s = 6'd0;
    logic [23:0] in_data_s = 24'd0;
    logic        out_ready_s = 1'b0;
    logic [5:0]  in_ready;
    logic        out_valid, out_last, err_sel;
    logic [3:0]  out_data;
    logic [2:0]  out_ch;

    int n_checks = 0;
    int n_pass   = 0;

    // Model state, straight from the behavioural description.
    logic       m_ov = 1'b0, m_ol = 1'b0, m_err = 1'b0;
    logic [3:0] m_od = 4'd0;
    logic [2:0] m_och = 3'd0;
    int         m_ptr = 0, m_lock = 0, m_lock_ch = 0;

    always #5 clk = ~clk;

    stream_sel_mux #(.N_CH(N_CH), .WIDTH(WIDTH)) dut (
        .clk       (clk),
        .areset_n  (areset_n),
        .mode      (mode_s),
        .sel       (sel_s),
        .in_valid  (in_valid_s),
        .in_ready  (in_ready),
        .in_data   (in_data_s),
        .in_last   (in_last_s),
        .out_valid (out_valid),
        .out_ready (out_ready_s),
        .out_data  (out_data),
        .out_last  (out_last),
        .out_ch    (out_ch),
        .err_sel   (err_sel)
    );

    function automatic int m_grant();
        if (mode_s == 1'b0) begin
            if (int'(sel_s) < N_CH && in_valid_s[sel_s]) return int'(sel_s);
            return -1;
        end
        if (m_lock != 0) return in_valid_s[m_lock_ch] ? m_lock_ch : -1;
        for (int k = 0; k < N_CH; k++) begin
            if (in_valid_s[(m_ptr + k) % N_CH]) return (m_ptr + k) % N_CH;
        end
        return -1;
    endfunction

    function automatic logic [5:0] m_ready();
        logic [5:0] r = 6'd0;
        int g = m_grant();
        if (g >= 0 && (!m_ov || out_ready_s)) r[g] = 1'b1;
        return r;
    endfunction

    function automatic logic [9:0] m_out();
        return {m_ov, m_od, m_ol, m_och, m_err};
    endfunction

    function automatic logic [9:0] dut_out();
        return {out_valid, out_data, out_last, out_ch, err_sel};
    endfunction

    task automatic m_reset();
        m_ov = 1'b0; m_od = 4'd0; m_ol = 1'b0; m_och = 3'd0; m_err = 1'b0;
        m_ptr = 0; m_lock = 0; m_lock_ch = 0;
    endtask

    task automatic drive(input logic md, input logic [2:0] s, input logic [5:0] v,
                         input logic [23:0] d, input logic [5:0] l, input logic ordy);
        mode_s = md; sel_s = s; in_valid_s = v; in_data_s = d; in_last_s = l; out_ready_s = ordy;
        #1;
    endtask

    // Advance the model by one clock using the current inputs, then step the DUT.
    task automatic tick();
        int   g   = m_grant();
        logic ld  = !m_ov || out_ready_s;
        logic err = (mode_s == 1'b0) && (int'(sel_s) >= N_CH) && (|in_valid_s);
        if (g >= 0 && ld) begin
            m_ov = 1'b1; m_od = in_data_s[g*4 +: 4]; m_ol = in_last_s[g]; m_och = 3'(g);
            if (mode_s == 1'b1) begin
                if (in_last_s[g]) begin m_lock = 0; m_ptr = (g + 1) % N_CH; end
                else begin m_lock = 1; m_lock_ch = g; end
            end
        end else if (ld) begin
            m_ov = 1'b0; m_od = 4'd0; m_ol = 1'b0;
        end
        m_err = err;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        areset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (dut_out() !== 10'd0) $display("FAIL reset_out: got %h expected %h", dut_out(), 10'd0);
        else n_pass++;
        @(negedge clk);
        areset_n = 1'b1;
        m_reset();
    endtask

    task automatic test_sel();
        drive(1'b0, 3'd3, 6'b001000, 24'h00A000, 6'b000000, 1'b1);
        n_checks++;
        if (in_ready !== 6'b001000) $display("FAIL sel_ready: got %b expected %b", in_ready, 6'b001000);
        else n_pass++;
        tick();
        n_checks++;
        if (out_valid !== 1'b1 || out_data !== 4'hA || out_ch !== 3'd3)
            $display("FAIL sel_beat: got v=%b d=%h ch=%0d expected v=1 d=a ch=3", out_valid, out_data, out_ch);
        else n_pass++;
        drive(1'b0, 3'd3, 6'b000000, 24'h00A000, 6'b000000, 1'b1);
        tick();
        n_checks++;
        if (out_valid !== 1'b0 || out_data !== 4'h0 || out_ch !== 3'd3)
            $display("FAIL sel_pop: got v=%b d=%h ch=%0d expected v=0 d=0 ch=3", out_valid, out_data, out_ch);
        else n_pass++;
    endtask

    task automatic test_sel_illegal();
        for (int s = 6; s < 8; s++) begin
            drive(1'b0, 3'(s), 6'b111111, 24'h123456, 6'b111111, 1'b1);
            n_checks++;
            if (in_ready !== 6'b000000) $display("FAIL illegal_ready: got %b expected %b", in_ready, 6'b000000);
            else n_pass++;
            tick();
            n_checks++;
            if (err_sel !== 1'b1 || out_valid !== 1'b0)
                $display("FAIL illegal_err: got err=%b v=%b expected err=1 v=0", err_sel, out_valid);
            else n_pass++;
        end
        drive(1'b0, 3'd7, 6'b000000, 24'h0, 6'b000000, 1'b1);
        tick();
        n_checks++;
        if (err_sel !== 1'b0) $display("FAIL illegal_err_clear: got %b expected 0", err_sel);
        else n_pass++;
    endtask

    task automatic test_rr_single();
        for (int k = 0; k < 7; k++) begin
            drive(1'b1, 3'd0, 6'b111111, 24'($urandom), 6'b111111, 1'b1);
            tick();
            n_checks++;
            if (out_valid !== 1'b1 || out_ch !== 3'(k % N_CH))
                $display("FAIL rr_single: got v=%b ch=%0d expected v=1 ch=%0d", out_valid, out_ch, k % N_CH);
            else n_pass++;
        end
    endtask

    task automatic test_rr_lock();
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 3'd0, 6'b010100, 24'($urandom), (k == 2) ? 6'b010100 : 6'b010000, 1'b1);
            n_checks++;
            if (in_ready !== 6'b000100) $display("FAIL lock_ready: got %b expected %b", in_ready, 6'b000100);
            else n_pass++;
            tick();
            n_checks++;
            if (out_ch !== 3'd2 || dut_out() !== m_out())
                $display("FAIL lock_beat: got ch=%0d out=%h expected ch=2 out=%h", out_ch, dut_out(), m_out());
            else n_pass++;
        end
        drive(1'b1, 3'd0, 6'b010000, 24'($urandom), 6'b010000, 1'b1);
        tick();
        n_checks++;
        if (out_ch !== 3'd4 || dut_out() !== m_out())
            $display("FAIL lock_after: got ch=%0d out=%h expected ch=4 out=%h", out_ch, dut_out(), m_out());
        else n_pass++;
    endtask

    task automatic test_backpressure();
        logic [3:0] d2;
        drive(1'b0, 3'd1, 6'b000010, 24'h000050, 6'b000000, 1'b1);
        tick();
        d2 = 4'h9;
        for (int k = 0; k < 3; k++) begin
            drive(1'b0, 3'd1, 6'b000010, {16'h0, d2, 4'h0}, 6'b000000, 1'b0);
            n_checks++;
            if (in_ready !== 6'b000000) $display("FAIL bp_ready: got %b expected %b", in_ready, 6'b000000);
            else n_pass++;
            tick();
            n_checks++;
            if (out_data !== 4'h5 || out_ch !== 3'd1 || out_valid !== 1'b1)
                $display("FAIL bp_hold: got v=%b d=%h ch=%0d expected v=1 d=5 ch=1", out_valid, out_data, out_ch);
            else n_pass++;
        end
        drive(1'b0, 3'd1, 6'b000010, {16'h0, d2, 4'h0}, 6'b000000, 1'b1);
        tick();
        n_checks++;
        if (out_data !== d2 || out_valid !== 1'b1)
            $display("FAIL bp_release: got v=%b d=%h expected v=1 d=%h", out_valid, out_data, d2);
        else n_pass++;
        drive(1'b0, 3'd1, 6'b000000, 24'h0, 6'b000000, 1'b1);
        tick();
        n_checks++;
        if (out_valid !== 1'b0) $display("FAIL bp_drain: got v=%b expected v=0", out_valid);
        else n_pass++;
    endtask

    task automatic test_mode_switch();
        drive(1'b1, 3'd0, 6'b001000, 24'($urandom), 6'b000000, 1'b1);
        tick();
        drive(1'b0, 3'd1, 6'b001010, 24'($urandom), 6'b000000, 1'b1);
        n_checks++;
        if (in_ready !== 6'b000010) $display("FAIL switch_sel_ready: got %b expected %b", in_ready, 6'b000010);
        else n_pass++;
        tick();
        drive(1'b1, 3'd0, 6'b111111, 24'($urandom), 6'b111111, 1'b1);
        n_checks++;
        if (in_ready !== 6'b001000) $display("FAIL switch_resume_ready: got %b expected %b", in_ready, 6'b001000);
        else n_pass++;
        tick();
        n_checks++;
        if (out_ch !== 3'd3 || dut_out() !== m_out())
            $display("FAIL switch_resume: got ch=%0d out=%h expected ch=3 out=%h", out_ch, dut_out(), m_out());
        else n_pass++;
    endtask

    task automatic test_async_reset();
        drive(1'b1, 3'd0, 6'b100000, 24'h700000, 6'b000000, 1'b1);
        tick();
        areset_n = 1'b0;
        #1;
        n_checks++;
        if (dut_out() !== 10'd0) $display("FAIL areset_clear: got %h expected %h", dut_out(), 10'd0);
        else n_pass++;
        m_reset();
        @(negedge clk);
        areset_n = 1'b1;
        drive(1'b1, 3'd0, 6'b111111, 24'($urandom), 6'b111111, 1'b1);
        tick();
        n_checks++;
        if (out_ch !== 3'd0 || out_valid !== 1'b1)
            $display("FAIL areset_restart: got v=%b ch=%0d expected v=1 ch=0", out_valid, out_ch);
        else n_pass++;
    endtask

    task automatic test_random();
        for (int k = 0; k < 400; k++) begin
            drive(($urandom_range(0, 3) != 0), 3'($urandom_range(0, 7)), 6'($urandom),
                  24'($urandom), 6'($urandom), ($urandom_range(0, 3) != 0));
            n_checks++;
            if (in_ready !== m_ready())
                $display("FAIL rand_ready@%0d: got %b expected %b", k, in_ready, m_ready());
            else n_pass++;
            tick();
            n_checks++;
            if (dut_out() !== m_out())
                $display("FAIL rand_out@%0d: got %h expected %h", k, dut_out(), m_out());
            else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_sel();
        test_sel_illegal();
        test_rr_single();
        test_rr_lock();
        test_backpressure();
        test_mode_switch();
        test_async_reset();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
